// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and helpers for the bus master.
// Holds the htrans/hburst/hsize/hresp encodings, the master FSM state enum
// and small helpers that map a burst code onto a beat count.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ADDR      = 2'd1,
    ST_DATA_LAST = 2'd2,
    ST_ERR_WAIT  = 2'd3
  } mst_state_t;

  // Wide enough to hold a beat count of 16.
  localparam int BEAT_CNT_W = 5;

  // Only the fixed-length incrementing bursts are supported; anything else
  // (INCR, wrapping bursts) is issued as a single transfer.
  function automatic hburst_t burst_normalize(input logic [2:0] code);
    case (code)
      3'd3:    return HBURST_INCR4;
      3'd5:    return HBURST_INCR8;
      3'd7:    return HBURST_INCR16;
      default: return HBURST_SINGLE;
    endcase
  endfunction

  function automatic logic [BEAT_CNT_W-1:0] burst_beats(input hburst_t burst);
    case (burst)
      HBURST_INCR4:  return 5'd4;
      HBURST_INCR8:  return 5'd8;
      HBURST_INCR16: return 5'd16;
      default:       return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_master_addr_gen.sv
// ahb_master_addr_gen: burst address register, size-based incrementer and
// remaining-beat counter. load takes a fresh start address and beat count;
// advance steps to the next beat. last is high while the final beat's
// address is being presented.
module ahb_master_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hrst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [BEAT_CNT_W-1:0] load_beats,
  input  logic                  advance,
  input  logic [2:0]            size,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BEAT_CNT_W-1:0] beats_q, beats_d;

  // Next address/count: load wins, otherwise step by one transfer size (wraps naturally).
  always_comb begin
    addr_d  = addr_q;
    beats_d = beats_q;
    if (load) begin
      addr_d  = load_addr;
      beats_d = load_beats;
    end else if (advance) begin
      addr_d = addr_q + (ADDR_ONE << size);
      if (beats_q != '0) begin
        beats_d = beats_q - 5'd1;
      end
    end
  end

  // Address and beat counter registers.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      addr_q  <= '0;
      beats_q <= '0;
    end else begin
      addr_q  <= addr_d;
      beats_q <= beats_d;
    end
  end

  assign addr = addr_q;
  assign last = (beats_q == 5'd1);

endmodule

// File: rtl/ahb_master.sv
// ahb_master: AHB-Lite master turning single read/write commands into
// pipelined address/data phases, with write-data gating (BUSY/IDLE insertion),
// wait-state handling and two-cycle ERROR responses.
// Optional build macro AHB_MASTER_ERR_ABORT_EN: when defined, the first ERROR
// cycle cancels the pending address phase and drops the rest of the burst;
// when undefined the burst always runs to completion.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hrst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [2:0]            cmd_burst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [1:0]            htrans,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  // Largest size the data bus can carry in one beat.
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  mst_state_t            state_q, state_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  hburst_t               burst_q, burst_d;
  logic                  first_q, first_d;          // next beat is the NONSEQ one
  logic                  hold_q, hold_d;            // active address stalled by hready=0
  logic                  addr_done_q, addr_done_d;  // last address phase accepted
  logic                  dphase_q, dphase_d;        // a data phase is in progress
  logic                  err_sticky_q, err_sticky_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  cmd_ready_q, cmd_ready_d;

  logic                  load;
  logic                  last;
  logic                  err_resp;
  logic                  err_first;
  logic                  data_done;
  logic                  addr_en;
  logic                  beat_ready;
  logic                  addr_acc;
  htrans_t               htrans_c;

  ahb_master_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .hclk      (hclk),
    .hrst_n    (hrst_n),
    .load      (load),
    .load_addr (cmd_addr),
    .load_beats(burst_beats(burst_normalize(cmd_burst))),
    .advance   (addr_acc),
    .size      (size_q),
    .addr      (haddr),
    .last      (last)
  );

  // Decide what the address bus shows this cycle and whether it is taken.
  always_comb begin
    err_resp  = dphase_q && (hresp_t'(hresp) == HRESP_ERROR);
    err_first = err_resp && !hready;
    data_done = dphase_q && hready;
`ifdef AHB_MASTER_ERR_ABORT_EN
    // Any ERROR cycle cancels the pending address; ERR_WAIT issues nothing.
    addr_en = (state_q == ST_ADDR) && !err_resp;
`else
    // The burst keeps issuing through the error response.
    addr_en = (state_q == ST_ADDR) || ((state_q == ST_ERR_WAIT) && !addr_done_q);
`endif
    // Once an address is on the bus it stays there even if wr_valid drops.
    beat_ready = !write_q || wr_valid || hold_q;
    addr_acc   = addr_en && beat_ready && hready;
    htrans_c   = HTRANS_IDLE;
    if (addr_en) begin
      if (beat_ready) begin
        htrans_c = first_q ? HTRANS_NONSEQ : HTRANS_SEQ;
      end else begin
        htrans_c = first_q ? HTRANS_IDLE : HTRANS_BUSY;
      end
    end
  end

  // Next-state, command latch, data-path and status pulse computation.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    burst_d      = burst_q;
    first_d      = first_q;
    addr_done_d  = addr_done_q;
    err_sticky_d = err_sticky_q;
    hwdata_d     = hwdata_q;
    rd_data_d    = rd_data_q;
    hold_d       = addr_en && beat_ready && !hready;
    dphase_d     = hready ? addr_acc : dphase_q;
    rd_valid_d   = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    load         = 1'b0;

    if (addr_acc) begin
      first_d = 1'b0;
      if (write_q) begin
        hwdata_d = wr_data;
      end
      if (last) begin
        addr_done_d = 1'b1;
      end
    end

    if (data_done && !err_resp && !write_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = hrdata;
    end

    if (err_first) begin
      err_sticky_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          load         = 1'b1;
          write_d      = cmd_write;
          size_d       = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
          burst_d      = burst_normalize(cmd_burst);
          first_d      = 1'b1;
          addr_done_d  = 1'b0;
          err_sticky_d = 1'b0;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (err_first) begin
          state_d = ST_ERR_WAIT;
        end else if (addr_acc && last) begin
          state_d = ST_DATA_LAST;
        end
      end
      ST_DATA_LAST: begin
        if (err_first) begin
          state_d = ST_ERR_WAIT;
        end else if (hready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = err_sticky_q || err_resp;
        end
      end
      ST_ERR_WAIT: begin
        if (hready) begin
`ifdef AHB_MASTER_ERR_ABORT_EN
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
`else
          if (addr_done_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (addr_acc && last) begin
            state_d = ST_DATA_LAST;
          end else begin
            state_d = ST_ADDR;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset clears everything, aborting any burst.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      size_q       <= '0;
      burst_q      <= HBURST_SINGLE;
      first_q      <= 1'b0;
      hold_q       <= 1'b0;
      addr_done_q  <= 1'b0;
      dphase_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      hwdata_q     <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      first_q      <= first_d;
      hold_q       <= hold_d;
      addr_done_q  <= addr_done_d;
      dphase_q     <= dphase_d;
      err_sticky_q <= err_sticky_d;
      hwdata_q     <= hwdata_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = addr_acc && write_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign hwrite    = write_q;
  assign hsize     = size_q;
  assign hburst    = burst_q;
  assign htrans    = htrans_c;
  assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: directed self-checking bench for ahb_master.
// Each scenario task drives a command and a per-cycle bus script, records a
// cycle trace, then compares it against hand-derived expectations.
// Build with +define+AHB_MASTER_ERR_ABORT_EN to check the abort variant.
module tb_ahb_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          hclk = 1'b0;
  logic          hrst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [2:0]    cmd_size = '0;
  logic [2:0]    cmd_burst = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          err;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [1:0]    htrans;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata = '0;
  logic          hready = 1'b1;
  logic          hresp = 1'b0;

  always #5 hclk = ~hclk;

  ahb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .hclk(hclk), .hrst_n(hrst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .htrans(htrans), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]  tr_htrans [0:63];
  logic [31:0] tr_haddr  [0:63];
  logic [31:0] tr_hwdata [0:63];
  logic        tr_wr_ready [0:63];
  logic [31:0] rd_log    [0:31];
  logic [31:0] wdata_tab [0:31];
  int          ncyc, nrd, nwr, ndone, done_cyc;
  logic        done_err;

  // Present a command and wait (bounded) for it to be accepted at the next edge.
  task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                           input logic [2:0] bu);
    int waited;
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_burst = bu;
    hready = 1'b1; hresp = 1'b0; wr_valid = 1'b0;
    ncyc = 0; nrd = 0; nwr = 0; ndone = 0; done_cyc = -1; done_err = 1'b0;
    #1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge hclk); #1; waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
    end
    $display("cmd write=%0b addr=%h size=%0d burst=%0d", wr, a, sz, bu);
  endtask

  // One bus cycle: drive slave response and write stream, then record outputs.
  task automatic bus_cycle(input logic rdy, input logic rsp, input logic wv);
    @(negedge hclk);
    cmd_valid = 1'b0;
    hready = rdy; hresp = rsp; wr_valid = wv;
    hrdata = 32'(ncyc);
    wr_data = (nwr < 32) ? wdata_tab[nwr] : 32'h0;
    #1;
    if (ncyc < 64) begin
      tr_htrans[ncyc] = htrans; tr_haddr[ncyc] = haddr;
      tr_hwdata[ncyc] = hwdata; tr_wr_ready[ncyc] = wr_ready;
    end
    if (rd_valid && nrd < 32) rd_log[nrd] = rd_data;
    if (rd_valid) nrd++;
    if (wr_ready) nwr++;
    if (done) begin ndone++; done_cyc = ncyc; done_err = err; end
    ncyc++;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({haddr, hwrite, hsize, hburst, htrans, hwdata, cmd_ready, wr_ready, rd_data,
         rd_valid, done, err} !== '0) begin
      errors++; $display("FAIL reset_outputs: haddr=%h htrans=%0d cmd_ready=%b required all 0",
                         haddr, htrans, cmd_ready);
    end
    @(negedge hclk); hrst_n = 1'b1; #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready: got %b required 0", cmd_ready);
    end
    @(negedge hclk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || htrans !== 2'b00) begin
      errors++; $display("FAIL reset_idle: cmd_ready=%b htrans=%0d required 1/0", cmd_ready, htrans);
    end
    $display("reset sequence checked");
  endtask

  task automatic test_write_single();
    wdata_tab[0] = 32'hDEADBEEF;
    issue_cmd(1'b1, 32'h10, 3'd2, 3'd0);
    for (int c = 0; c < 5; c++) bus_cycle(1'b1, 1'b0, 1'b1);
    checks++;
    if (tr_htrans[0] !== 2'b10 || tr_haddr[0] !== 32'h10 || tr_wr_ready[0] !== 1'b1) begin
      errors++; $display("FAIL single_addr: htrans=%0d haddr=%h wr_ready=%b required 2/10/1",
                         tr_htrans[0], tr_haddr[0], tr_wr_ready[0]);
    end
    checks++;
    if (hwrite !== 1'b1 || hsize !== 3'd2 || hburst !== 3'd0) begin
      errors++; $display("FAIL single_ctrl: hwrite=%b hsize=%0d hburst=%0d required 1/2/0",
                         hwrite, hsize, hburst);
    end
    checks++;
    if (tr_hwdata[1] !== 32'hDEADBEEF || tr_htrans[1] !== 2'b00) begin
      errors++; $display("FAIL single_data: hwdata=%h htrans=%0d required deadbeef/0",
                         tr_hwdata[1], tr_htrans[1]);
    end
    checks++;
    if (done_cyc !== 2 || ndone !== 1 || done_err !== 1'b0) begin
      errors++; $display("FAIL single_done: cycle=%0d count=%0d err=%b required 2/1/0",
                         done_cyc, ndone, done_err);
    end
  endtask

  task automatic test_read_incr4();
    logic [31:0] exp_addr [0:3];
    logic [1:0]  exp_tr [0:3];
    exp_addr[0] = 32'h40; exp_addr[1] = 32'h44; exp_addr[2] = 32'h48; exp_addr[3] = 32'h4C;
    exp_tr[0] = 2'b10; exp_tr[1] = 2'b11; exp_tr[2] = 2'b11; exp_tr[3] = 2'b11;
    issue_cmd(1'b0, 32'h40, 3'd2, 3'd3);
    for (int c = 0; c < 8; c++) bus_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tr_htrans[i] !== exp_tr[i] || tr_haddr[i] !== exp_addr[i]) begin
        errors++; $display("FAIL incr4_beat%0d: htrans=%0d haddr=%h required %0d/%h",
                           i, tr_htrans[i], tr_haddr[i], exp_tr[i], exp_addr[i]);
      end
    end
    checks++;
    if (nrd !== 4) begin
      errors++; $display("FAIL incr4_rd_count: got %0d required 4", nrd);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log[i] !== 32'(i + 1)) begin
        errors++; $display("FAIL incr4_rd%0d: got %h required %h", i, rd_log[i], i + 1);
      end
    end
    checks++;
    if (done_cyc !== 5 || done_err !== 1'b0 || tr_htrans[4] !== 2'b00) begin
      errors++; $display("FAIL incr4_done: cycle=%0d err=%b htrans4=%0d required 5/0/0",
                         done_cyc, done_err, tr_htrans[4]);
    end
  endtask

  task automatic test_write_incr8_wait();
    for (int i = 0; i < 8; i++) wdata_tab[i] = 32'h1000 + 32'(i);
    issue_cmd(1'b1, 32'h100, 3'd2, 3'd5);
    for (int c = 0; c < 14; c++) bus_cycle(!(c == 2 || c == 3), 1'b0, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      checks++;
      if (tr_htrans[c] !== 2'b11 || tr_haddr[c] !== 32'h108 || tr_hwdata[c] !== 32'h1001) begin
        errors++; $display("FAIL incr8_stall_c%0d: htrans=%0d haddr=%h hwdata=%h required 3/108/1001",
                           c, tr_htrans[c], tr_haddr[c], tr_hwdata[c]);
      end
    end
    checks++;
    if (tr_wr_ready[2] !== 1'b0 || tr_wr_ready[3] !== 1'b0 || tr_hwdata[5] !== 32'h1002) begin
      errors++; $display("FAIL incr8_resume: wr_ready=%b%b hwdata5=%h required 00/1002",
                         tr_wr_ready[2], tr_wr_ready[3], tr_hwdata[5]);
    end
    checks++;
    if (nwr !== 8 || done_cyc !== 11 || ndone !== 1) begin
      errors++; $display("FAIL incr8_totals: wr_ready=%0d done_cycle=%0d done_count=%0d required 8/11/1",
                         nwr, done_cyc, ndone);
    end
  endtask

  task automatic test_write_busy();
    for (int i = 0; i < 4; i++) wdata_tab[i] = 32'hB000 + 32'(i);
    issue_cmd(1'b1, 32'h0, 3'd2, 3'd3);
    for (int c = 0; c < 10; c++) bus_cycle(1'b1, 1'b0, !(c >= 2 && c <= 4));
    for (int c = 2; c <= 4; c++) begin
      checks++;
      if (tr_htrans[c] !== 2'b01 || tr_haddr[c] !== 32'h08) begin
        errors++; $display("FAIL busy_c%0d: htrans=%0d haddr=%h required 1/08", c, tr_htrans[c], tr_haddr[c]);
      end
    end
    checks++;
    if (tr_htrans[5] !== 2'b11 || tr_haddr[5] !== 32'h08 || tr_haddr[6] !== 32'h0C) begin
      errors++; $display("FAIL busy_resume: htrans=%0d haddr5=%h haddr6=%h required 3/08/0c",
                         tr_htrans[5], tr_haddr[5], tr_haddr[6]);
    end
    checks++;
    if (nwr !== 4 || done_cyc !== 8 || tr_hwdata[6] !== 32'hB002) begin
      errors++; $display("FAIL busy_totals: wr_ready=%0d done_cycle=%0d hwdata6=%h required 4/8/b002",
                         nwr, done_cyc, tr_hwdata[6]);
    end
    // First beat waiting for write data shows IDLE, not BUSY.
    wdata_tab[0] = 32'hC0FFEE00;
    issue_cmd(1'b1, 32'h80, 3'd2, 3'd0);
    for (int c = 0; c < 6; c++) bus_cycle(1'b1, 1'b0, c >= 2);
    checks++;
    if (tr_htrans[0] !== 2'b00 || tr_htrans[1] !== 2'b00 || tr_htrans[2] !== 2'b10) begin
      errors++; $display("FAIL first_wait: htrans=%0d,%0d,%0d required 0,0,2",
                         tr_htrans[0], tr_htrans[1], tr_htrans[2]);
    end
    checks++;
    if (tr_hwdata[3] !== 32'hC0FFEE00 || done_cyc !== 4 || nwr !== 1) begin
      errors++; $display("FAIL first_wait_done: hwdata=%h done_cycle=%0d wr=%0d required c0ffee00/4/1",
                         tr_hwdata[3], done_cyc, nwr);
    end
  endtask

  task automatic test_read_error();
    issue_cmd(1'b0, 32'h40, 3'd2, 3'd3);
    for (int c = 0; c < 10; c++) bus_cycle(c != 2, (c == 2 || c == 3), 1'b0);
`ifdef AHB_MASTER_ERR_ABORT_EN
    checks++;
    if (tr_htrans[2] !== 2'b00 || tr_htrans[3] !== 2'b00) begin
      errors++; $display("FAIL err_abort_htrans: got %0d,%0d required 0,0", tr_htrans[2], tr_htrans[3]);
    end
    checks++;
    if (nrd !== 1 || rd_log[0] !== 32'd1) begin
      errors++; $display("FAIL err_abort_rd: count=%0d data=%h required 1/1", nrd, rd_log[0]);
    end
    checks++;
    if (done_cyc !== 4 || done_err !== 1'b1 || ndone !== 1) begin
      errors++; $display("FAIL err_abort_done: cycle=%0d err=%b count=%0d required 4/1/1",
                         done_cyc, done_err, ndone);
    end
`else
    checks++;
    if (tr_htrans[2] !== 2'b11 || tr_haddr[2] !== 32'h48 || tr_haddr[4] !== 32'h4C) begin
      errors++; $display("FAIL err_cont_htrans: htrans=%0d haddr2=%h haddr4=%h required 3/48/4c",
                         tr_htrans[2], tr_haddr[2], tr_haddr[4]);
    end
    checks++;
    if (nrd !== 3 || rd_log[0] !== 32'd1 || rd_log[1] !== 32'd4 || rd_log[2] !== 32'd5) begin
      errors++; $display("FAIL err_cont_rd: count=%0d data=%h,%h,%h required 3/1,4,5",
                         nrd, rd_log[0], rd_log[1], rd_log[2]);
    end
    checks++;
    if (done_cyc !== 6 || done_err !== 1'b1 || ndone !== 1) begin
      errors++; $display("FAIL err_cont_done: cycle=%0d err=%b count=%0d required 6/1/1",
                         done_cyc, done_err, ndone);
    end
`endif
  endtask

  task automatic test_size_clamp();
    // Oversized hsize clamps to the bus width; INCR code is issued as SINGLE.
    issue_cmd(1'b0, 32'h20, 3'd7, 3'd1);
    for (int c = 0; c < 4; c++) bus_cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (hsize !== 3'd2 || hburst !== 3'd0 || hwrite !== 1'b0 || tr_htrans[0] !== 2'b10) begin
      errors++; $display("FAIL clamp_ctrl: hsize=%0d hburst=%0d hwrite=%b htrans=%0d required 2/0/0/2",
                         hsize, hburst, hwrite, tr_htrans[0]);
    end
    checks++;
    if (done_cyc !== 2 || done_err !== 1'b0 || nrd !== 1 || rd_log[0] !== 32'd1) begin
      errors++; $display("FAIL clamp_done: cycle=%0d err=%b rd=%0d data=%h required 2/0/1/1",
                         done_cyc, done_err, nrd, rd_log[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    issue_cmd(1'b0, 32'h200, 3'd2, 3'd7);
    for (int c = 0; c < 5; c++) bus_cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (tr_htrans[4] !== 2'b11 || tr_haddr[4] !== 32'h210 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: htrans=%0d haddr=%h rd_valid=%b required 3/210/1",
                         tr_htrans[4], tr_haddr[4], rd_valid);
    end
    #2 hrst_n = 1'b0;
    #1;
    checks++;
    if ({haddr, hwrite, hsize, hburst, htrans, hwdata, cmd_ready, wr_ready, rd_data,
         rd_valid, done, err} !== '0) begin
      errors++; $display("FAIL midrst_outputs: haddr=%h htrans=%0d hburst=%0d rd_valid=%b required all 0",
                         haddr, htrans, hburst, rd_valid);
    end
    @(negedge hclk); hrst_n = 1'b1;
    ncyc = 0; ndone = 0;
    bus_cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (cmd_ready !== 1'b1 || tr_htrans[0] !== 2'b00) begin
      errors++; $display("FAIL midrst_ready: cmd_ready=%b htrans=%0d required 1/0", cmd_ready, tr_htrans[0]);
    end
    for (int c = 0; c < 4; c++) bus_cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL midrst_no_done: done pulses=%0d required 0", ndone);
    end
    $display("reset mid-burst checked");
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_incr4();
    test_write_incr8_wait();
    test_write_busy();
    test_read_error();
    test_size_clamp();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
